// File: rtl/neuron_pkg.sv
// Shared types, widths and saturation helper for the neuron sequencer.
package neuron_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PREF,
    ST_RUN,
    ST_FIN,
    ST_OUT
  } state_t;

  localparam int DATA_W  = 8;
  localparam int PROD_W  = 16;
  localparam int SAT_MAX = 127;
  localparam int SAT_MIN = -128;

  // Clamp a sign-extended value into the signed 8-bit output range.
  function automatic logic signed [DATA_W-1:0] sat_s8(input logic signed [31:0] v);
    if (v > 32'(SAT_MAX))
      return DATA_W'(SAT_MAX);
    else if (v < 32'(SAT_MIN))
      return DATA_W'(SAT_MIN);
    else
      return v[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/neuron_wmem.sv
// 256x8 simple dual-port weight RAM with one-cycle registered read and no reset.
import neuron_pkg::*;

module neuron_wmem (
  input  logic              clk,
  input  logic              we,
  input  logic [7:0]        waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [7:0]        raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [256];

  always_ff @(posedge clk) begin
    if (we)
      mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/neuron_seq.sv
// Sequencer for one fixed-point neuron: weight load, MAC over NUM_INPUTS activations,
// bias, shift and saturate. Define NEURON_SEQ_RELU_EN to clamp negative results to 0.
import neuron_pkg::*;

module neuron_seq #(
  parameter int NUM_INPUTS = 16,
  parameter int FRAC_BITS  = 4,
  parameter int ACC_W      = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wgt_load,
  input  logic       wgt_valid,
  input  logic [7:0] wgt_data,
  output logic       wgt_ready,
  input  logic       start,
  input  logic [7:0] bias_in,
  input  logic       x_valid,
  input  logic [7:0] x_data,
  output logic       x_ready,
  output logic       y_valid,
  output logic [7:0] y_data,
  input  logic       y_ready,
  output logic       busy,
  output logic       wgts_loaded
);

  localparam logic [8:0] LAST_IDX = 9'(NUM_INPUTS - 1);

  state_t                   state_reg;
  logic [8:0]               count_reg;
  logic signed [ACC_W-1:0]  acc_reg;

  logic                     x_acc;
  logic                     w_acc;
  logic [7:0]               rd_addr;
  logic signed [DATA_W-1:0] w_rd;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  bias_ext;
  logic signed [ACC_W-1:0]  shifted;
  logic signed [DATA_W-1:0] result;

  assign x_acc = x_valid & x_ready;
  assign w_acc = wgt_valid & wgt_ready;

  // Look one address ahead on an accept so the next weight is ready for back-to-back activations.
  assign rd_addr = (state_reg == ST_RUN && x_acc) ? 8'(count_reg + 9'd1) : count_reg[7:0];

  neuron_wmem u_wmem (
    .clk   (clk),
    .we    (w_acc),
    .waddr (count_reg[7:0]),
    .wdata (wgt_data),
    .raddr (rd_addr),
    .rdata (w_rd)
  );

  assign prod     = $signed(x_data) * w_rd;
  assign prod_ext = ACC_W'(prod);
  assign bias_ext = ACC_W'($signed(bias_in)) <<< FRAC_BITS;
  assign shifted  = acc_reg >>> FRAC_BITS;

`ifdef NEURON_SEQ_RELU_EN
  assign result = shifted[ACC_W-1] ? '0 : sat_s8(32'(shifted));
`else
  assign result = sat_s8(32'(shifted));
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      count_reg   <= '0;
      acc_reg     <= '0;
      wgt_ready   <= 1'b0;
      x_ready     <= 1'b0;
      y_valid     <= 1'b0;
      y_data      <= '0;
      busy        <= 1'b0;
      wgts_loaded <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (wgt_load) begin
            state_reg   <= ST_LOAD;
            count_reg   <= '0;
            wgts_loaded <= 1'b0;
            wgt_ready   <= 1'b1;
            busy        <= 1'b1;
          end else if (start && wgts_loaded) begin
            state_reg <= ST_PREF;
            count_reg <= '0;
            acc_reg   <= bias_ext;
            busy      <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (w_acc) begin
            count_reg <= count_reg + 9'd1;
            if (count_reg == LAST_IDX) begin
              state_reg   <= ST_IDLE;
              wgt_ready   <= 1'b0;
              busy        <= 1'b0;
              wgts_loaded <= 1'b1;
            end
          end
        end
        ST_PREF: begin
          state_reg <= ST_RUN;
          x_ready   <= 1'b1;
        end
        ST_RUN: begin
          if (x_acc) begin
            acc_reg   <= acc_reg + prod_ext;
            count_reg <= count_reg + 9'd1;
            if (count_reg == LAST_IDX) begin
              state_reg <= ST_FIN;
              x_ready   <= 1'b0;
            end
          end
        end
        ST_FIN: begin
          y_data    <= result;
          y_valid   <= 1'b1;
          state_reg <= ST_OUT;
        end
        ST_OUT: begin
          if (y_ready) begin
            y_valid   <= 1'b0;
            busy      <= 1'b0;
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_seq.sv
// Scoreboard bench for neuron_seq with NUM_INPUTS=4, FRAC_BITS=4.
module tb_neuron_seq;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wgt_load = 1'b0;
  logic       wgt_valid = 1'b0;
  logic [7:0] wgt_data = '0;
  logic       start = 1'b0;
  logic [7:0] bias_in = '0;
  logic       x_valid = 1'b0;
  logic [7:0] x_data = '0;
  logic       y_ready = 1'b0;
  logic       wgt_ready, x_ready, y_valid, busy, wgts_loaded;
  logic [7:0] y_data;

  int n_checks = 0;
  int n_fail = 0;
  int n_txn = 0;
  int exp_q[$];

  neuron_seq #(.NUM_INPUTS(N), .FRAC_BITS(4), .ACC_W(24)) dut (
    .clk         (clk),
    .reset       (reset),
    .wgt_load    (wgt_load),
    .wgt_valid   (wgt_valid),
    .wgt_data    (wgt_data),
    .wgt_ready   (wgt_ready),
    .start       (start),
    .bias_in     (bias_in),
    .x_valid     (x_valid),
    .x_data      (x_data),
    .x_ready     (x_ready),
    .y_valid     (y_valid),
    .y_data      (y_data),
    .y_ready     (y_ready),
    .busy        (busy),
    .wgts_loaded (wgts_loaded)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Output side of the scoreboard: a handshake is seen here one half-cycle before its edge.
  always @(negedge clk) begin
    if (y_valid && y_ready) begin
      if (exp_q.size() == 0) begin
        check_val("sb_unexpected_output", 1, 0);
      end else begin
        int e;
        e = exp_q.pop_front();
        n_txn++;
        $display("txn %0d: y_data=%0d expected=%0d", n_txn, int'($signed(y_data)), e);
        check_val("y_data", int'($signed(y_data)), e);
      end
    end
  end

  task automatic do_load(input int w[N], input bit with_start);
    wgt_load = 1'b1;
    start    = with_start;
    tick();
    wgt_load = 1'b0;
    start    = 1'b0;
    if (with_start) begin
      @(negedge clk);
      check_val("load_priority_wgt_ready", wgt_ready, 1);
      check_val("load_priority_x_ready", x_ready, 0);
    end
    for (int i = 0; i < N; i++) begin
      wgt_valid = 1'b1;
      wgt_data  = 8'(w[i]);
      tick();
    end
    wgt_valid = 1'b0;
    @(negedge clk);
    check_val("wgts_loaded_after_load", wgts_loaded, 1);
    check_val("busy_after_load", busy, 0);
    tick();
  endtask

  task automatic wait_accept();
    int n;
    n = 0;
    @(negedge clk);
    while (!x_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check_val("x_ready_timeout", 0, 1);
    tick();
  endtask

  task automatic run_eval(input int bias, input int xs[N], input int gap, input int hold, input int exp);
    logic [7:0] held;
    int n;
    exp_q.push_back(exp);
    y_ready = (hold == 0);
    bias_in = 8'(bias);
    start   = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < N; i++) begin
      x_valid = 1'b1;
      x_data  = 8'(xs[i]);
      wait_accept();
      x_valid = 1'b0;
      if (i < N - 1) repeat (gap) tick();
    end
    @(negedge clk);
    check_val("latency_fin_y_valid", y_valid, 0);
    @(negedge clk);
    check_val("latency_out_y_valid", y_valid, 1);
    held = y_data;
    if (hold > 0) begin
      repeat (hold) begin
        @(negedge clk);
        check_val("hold_y_valid", y_valid, 1);
        check_val("hold_y_data_stable", int'(y_data), int'(held));
        check_val("hold_busy", busy, 1);
      end
      @(posedge clk);
      #1;
      y_ready = 1'b1;
      @(negedge clk);
    end
    n = 0;
    @(negedge clk);
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_val("idle_after_handshake_busy", busy, 0);
    check_val("idle_after_handshake_y_valid", y_valid, 0);
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_busy"}, busy, 0);
    check_val({tag, "_wgt_ready"}, wgt_ready, 0);
    check_val({tag, "_x_ready"}, x_ready, 0);
    check_val({tag, "_y_valid"}, y_valid, 0);
    check_val({tag, "_y_data"}, int'(y_data), 0);
    check_val({tag, "_wgts_loaded"}, wgts_loaded, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int x1234[N] = '{1, 2, 3, 4};
    int x127[N]  = '{127, 127, 127, 127};
    int xmix[N]  = '{10, -5, 7, -4};
`ifdef NEURON_SEQ_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    repeat (3) tick();
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("reset");
    tick();

    // start with no resident weights must not leave IDLE
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    check_val("start_no_wgts_busy", busy, 0);
    tick();

    do_load('{16, 16, 16, 16}, 1'b1);
    run_eval(0, x1234, 0, 0, 10);
    run_eval(5, x1234, 0, 0, 15);

    do_load('{-16, -16, -16, -16}, 1'b0);
    run_eval(0, x1234, 0, 0, RELU ? 0 : -10);

    do_load('{127, 127, 127, 127}, 1'b0);
    run_eval(0, x127, 0, 0, 127);

    do_load('{-128, -128, -128, -128}, 1'b0);
    run_eval(0, x127, 0, 0, RELU ? 0 : -128);

    do_load('{16, 16, 16, 16}, 1'b0);
    run_eval(0, x1234, 2, 5, 10);

    // abort a run after two accepts
    bias_in = 8'd0;
    start   = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      x_valid = 1'b1;
      x_data  = 8'(i + 1);
      wait_accept();
    end
    x_valid = 1'b0;
    reset   = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("mid_run_reset");
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    check_val("start_after_reset_busy", busy, 0);
    tick();

    do_load('{32, -16, 48, 16}, 1'b0);
    run_eval(3, xmix, 0, 0, 45);

    check_val("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
